// File: rtl/id_fetch_latch.sv
// IF/ID pipeline register with branch/jump resolution that produces the next fetch address.
// Define ID_DELAY_SLOT_EN for MIPS delay-slot semantics; leave it undefined to squash the slot.
module id_fetch_latch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_EN,
  input  logic [31:0] v_PC_I,
  input  logic [31:0] instrI,
  input  logic [31:0] v_RS_D,
  input  logic [31:0] v_RT_D,
  output logic [31:0] v_PC_D,
  output logic [31:0] instrD,
  output logic        valid_D,
  output logic [31:0] v_NPC,
  output logic        jump_D
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        rs_eq;
  logic        take;
  logic [31:0] target;
  logic [31:0] br_offset;

  assign opcode    = instrD[31:26];
  assign funct     = instrD[5:0];
  assign rs_eq     = (v_RS_D == v_RT_D);
  assign br_offset = {{14{instrD[15]}}, instrD[15:0], 2'b00};

  always_comb begin
    take   = 1'b0;
    target = v_RS_D;
    case (opcode)
      OP_BEQ: begin
        take   = rs_eq;
        target = v_PC_D + 32'd4 + br_offset;
      end
      OP_BNE: begin
        take   = ~rs_eq;
        target = v_PC_D + 32'd4 + br_offset;
      end
      OP_J, OP_JAL: begin
        take   = 1'b1;
        target = {v_PC_D[31:28], instrD[25:0], 2'b00};
      end
      OP_SPECIAL: take = (funct == FN_JR);
      default: take = 1'b0;
    endcase
  end

  // A bubble in D must never redirect fetch, whatever its bits decode to.
  assign jump_D = valid_D & take;
  assign v_NPC  = jump_D ? target : v_PC_I + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_PC_D  <= RESET_PC;
      instrD  <= NOP_INSTR;
      valid_D <= 1'b0;
    end else if (D_EN) begin
`ifndef ID_DELAY_SLOT_EN
      if (jump_D) begin
        v_PC_D  <= v_PC_I;
        instrD  <= NOP_INSTR;
        valid_D <= 1'b0;
      end else
`endif
      begin
        v_PC_D  <= v_PC_I;
        instrD  <= instrI;
        valid_D <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_fetch_latch.sv
// Randomized and directed bench for id_fetch_latch against a behavioural IF/ID model.
// Honours ID_DELAY_SLOT_EN the same way the design does.
module tb_id_fetch_latch;

`ifdef ID_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        D_EN;
  logic [31:0] v_PC_I;
  logic [31:0] instrI;
  logic [31:0] v_RS_D;
  logic [31:0] v_RT_D;
  logic [31:0] v_PC_D;
  logic [31:0] instrD;
  logic        valid_D;
  logic [31:0] v_NPC;
  logic        jump_D;

  int checks;
  int failures;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_known;

  id_fetch_latch dut (
    .clk(clk), .reset(reset), .D_EN(D_EN), .v_PC_I(v_PC_I), .instrI(instrI),
    .v_RS_D(v_RS_D), .v_RT_D(v_RT_D), .v_PC_D(v_PC_D), .instrD(instrD),
    .valid_D(valid_D), .v_NPC(v_NPC), .jump_D(jump_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {redirect, next fetch address} for the instruction the model holds in D.
  function automatic logic [32:0] model_next(input logic [31:0] pc_d, input logic [31:0] ins,
                                             input logic vld, input logic [31:0] rs,
                                             input logic [31:0] rt, input logic [31:0] pc_i);
    logic [5:0]  op;
    logic        take;
    logic [31:0] tgt;
    int          off;
    op   = ins[31:26];
    off  = int'($signed(ins[15:0]));
    take = 1'b0;
    tgt  = 32'd0;
    if (vld) begin
      case (op)
        6'd4: begin take = (rs == rt); tgt = pc_d + 32'd4 + 32'(off * 4); end
        6'd5: begin take = (rs != rt); tgt = pc_d + 32'd4 + 32'(off * 4); end
        6'd2, 6'd3: begin take = 1'b1; tgt = (pc_d & 32'hF000_0000) | (32'(ins[25:0]) << 2); end
        6'd0: begin take = (ins[5:0] == 6'd8); tgt = rs; end
        default: take = 1'b0;
      endcase
    end
    return {take, take ? tgt : pc_i + 32'd4};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs away from the active edge, then compare everything to the model.
  task automatic applyStimulus(input logic rst, input logic en, input logic [31:0] pci,
                               input logic [31:0] ins, input logic [31:0] rs,
                               input logic [31:0] rt);
    logic [32:0] nx;
    @(negedge clk);
    reset = rst; D_EN = en; v_PC_I = pci; instrI = ins; v_RS_D = rs; v_RT_D = rt;
    #1;
    if (m_known) begin
      nx = model_next(m_pc, m_instr, m_valid, rs, rt, pci);
      checkOutput("pc_d", v_PC_D, m_pc);
      checkOutput("instr_d", instrD, m_instr);
      checkOutput("valid_d", 32'(valid_D), 32'(m_valid));
      checkOutput("jump_d", 32'(jump_D), 32'(nx[32]));
      checkOutput("npc", v_NPC, nx[31:0]);
    end
  endtask

  task automatic tick();
    logic [32:0] nx;
    @(posedge clk);
    nx = model_next(m_pc, m_instr, m_valid, v_RS_D, v_RT_D, v_PC_I);
    if (reset) begin
      m_pc = 32'h0000_3000; m_instr = 32'd0; m_valid = 1'b0; m_known = 1'b1;
    end else if (D_EN && m_known) begin
      if (!DELAY_SLOT && nx[32]) begin
        m_pc = v_PC_I; m_instr = 32'd0; m_valid = 1'b0;
      end else begin
        m_pc = v_PC_I; m_instr = instrI; m_valid = 1'b1;
      end
    end
  endtask

  logic [31:0] held_pc;
  logic [31:0] r;

  initial begin
    checks = 0; failures = 0; m_known = 1'b0;
    m_pc = '0; m_instr = '0; m_valid = 1'b0;
    reset = 1'b1; D_EN = 1'b1; v_PC_I = 32'h3000; instrI = 32'h2408_0005;
    v_RS_D = '0; v_RT_D = '0;

    applyStimulus(1, 1, 32'h3000, 32'h2408_0005, 0, 0); tick();
    applyStimulus(1, 1, 32'h3000, 32'h2408_0005, 0, 0); tick();
    applyStimulus(0, 1, 32'h3000, 32'h0109_5020, 0, 0);
    checkOutput("rst_pc", v_PC_D, 32'h3000);
    checkOutput("rst_instr", instrD, 32'h0);
    checkOutput("rst_valid", 32'(valid_D), 32'h0);
    checkOutput("rst_npc", v_NPC, 32'h3004);
    tick();

    applyStimulus(0, 1, 32'h3004, 32'h0128_5022, 0, 0);
    checkOutput("seq_instr", instrD, 32'h0109_5020);
    checkOutput("seq_valid", 32'(valid_D), 32'h1);
    checkOutput("seq_npc", v_NPC, 32'h3008);
    tick();

    applyStimulus(0, 1, 32'h3010, 32'h1000_FFFC, 0, 0); tick();
    applyStimulus(0, 1, 32'h3014, 32'h0109_5020, 7, 7);
    checkOutput("beq_jump", 32'(jump_D), 32'h1);
    checkOutput("beq_npc", v_NPC, 32'h3004);
    tick();
    applyStimulus(0, 1, 32'h3004, 32'h0, 0, 0);
    checkOutput("beq_slot_valid", 32'(valid_D), DELAY_SLOT ? 32'h1 : 32'h0);
    tick();

    applyStimulus(0, 1, 32'h3020, 32'h0CC0_0100, 0, 0); tick();
    applyStimulus(0, 1, 32'h3024, 32'h0, 0, 0);
    checkOutput("jal_npc", v_NPC, 32'h0300_0400);
    tick();
    applyStimulus(0, 1, 32'h3028, 32'h03E0_0008, 0, 0); tick();
    applyStimulus(0, 1, 32'h302C, 32'h0, 32'h0000_3ABC, 0);
    checkOutput("jr_npc", v_NPC, 32'h3ABC);
    tick();

    applyStimulus(0, 1, 32'h3040, 32'h1400_0003, 0, 0); tick();
    held_pc = 32'h3040;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 32'h3044 + 32'(i * 4), 32'h0109_5020, 4, (i == 0) ? 5 : 4);
      checkOutput("stall_pc", v_PC_D, held_pc);
      checkOutput("stall_jump", 32'(jump_D), (i == 0) ? 32'h1 : 32'h0);
      tick();
    end
    applyStimulus(0, 1, 32'h3044, 32'h0, 4, 4); tick();
    applyStimulus(0, 1, 32'h3048, 32'h0, 4, 4);
    checkOutput("resume_pc", v_PC_D, 32'h3044);
    tick();

    applyStimulus(0, 1, 32'hFFFF_FFFC, 32'h1000_0010, 1, 1);
    checkOutput("wrap_npc", v_NPC, 32'h0);
    tick();
    applyStimulus(1, 1, 32'h0000_0000, 32'h0, 1, 1);
    checkOutput("pre_rst_jump", 32'(jump_D), 32'h1);
    tick();
    applyStimulus(0, 1, 32'h3000, 32'h0, 1, 1);
    checkOutput("post_rst_jump", 32'(jump_D), 32'h0);
    tick();

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [31:0] pci;
      r = $urandom();
      case ($urandom_range(0, 5))
        0: ins = {6'd4, r[25:0]};
        1: ins = {6'd5, r[25:0]};
        2: ins = {6'd2, r[25:0]};
        3: ins = {6'd3, r[25:0]};
        4: ins = {6'd0, r[25:6], 6'd8};
        default: ins = r;
      endcase
      pci = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0, pci, ins,
                    32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
